// File: rtl/mips_pkg.sv
// Shared definitions for the parametrised MIPS-style lab core: opcodes,
// FSM states, fault causes, ALU selector and the instruction word layout.
package mips_pkg;

    localparam logic [7:0] OP_NOOP = 8'h00;
    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_LDNM = 8'h02;
    localparam logic [7:0] OP_STR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h04;
    localparam logic [7:0] OP_SUB  = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_AND  = 8'h07;
    localparam logic [7:0] OP_JMP  = 8'h08;
    localparam logic [7:0] OP_JMP0 = 8'h09;
    localparam logic [7:0] OP_PUSH = 8'h0A;
    localparam logic [7:0] OP_POP  = 8'h0B;
    localparam logic [7:0] OP_HALT = 8'h0C;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_ILLEGAL   = 3'd1;
    localparam logic [2:0] FC_STK_FULL  = 3'd2;
    localparam logic [2:0] FC_STK_EMPTY = 3'd3;
    localparam logic [2:0] FC_INDEX     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } state_e;

    // Low two opcode bits of ADD/SUB/XOR/AND map directly onto this order.
    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational datapath ALU; wraps modulo 2^DATA_W, no flags.
module mips_alu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   y
);

    // Select the result of the requested operation.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_XOR: y = a ^ b;
            ALU_AND: y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mips_core_p.sv
// Parametrised two-cycle fetch/execute core with host load port and faults.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start; host may load IMEM/DMEM
// ST_FETCH | instruction register <= IMEM[pc]
// ST_EXEC  | decode, fault check, all architectural writes at cycle end
// ST_HALT  | HALT executed; pc holds the HALT address; waits for start
// ST_FAULT | fault detected; pc holds faulting address, fault_code set
module mips_core_p
    import mips_pkg::*;
#(
    parameter int  DATA_W      = 32,
    parameter int  NUM_REGS    = 16,
    parameter int  IMEM_DEPTH  = 32,
    parameter int  DMEM_DEPTH  = 32,
    parameter int  STACK_DEPTH = 32,
    localparam int IA_W        = $clog2(IMEM_DEPTH),
    localparam int DA_W        = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              imem_we,
    input  logic [IA_W-1:0]   imem_addr,
    input  logic [31:0]       imem_wdata,
    input  logic              dmem_we,
    input  logic [DA_W-1:0]   dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [2:0]        fault_code,
    output logic [IA_W-1:0]   pc,
    output logic [DATA_W-1:0] ret_val
);

    localparam int RA_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SA_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);
    localparam logic [31:0] IMEM_U     = 32'(IMEM_DEPTH);
    localparam logic [31:0] DMEM_U     = 32'(DMEM_DEPTH);
    localparam logic [31:0] STACK_U    = 32'(STACK_DEPTH);

    state_e              state_q, state_d;
    logic [IA_W-1:0]     pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    instr_t              ir_q, ir_d;
    logic [2:0]          fault_code_q, fault_code_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic [31:0]         imem      [IMEM_DEPTH];
    logic [DATA_W-1:0]   dmem      [DMEM_DEPTH];
    logic [DATA_W-1:0]   stack_mem [STACK_DEPTH];

    logic                dmem_core_we;
    logic [DA_W-1:0]     dmem_core_addr;
    logic [DATA_W-1:0]   dmem_core_wdata;
    logic                stack_we;
    logic [DATA_W-1:0]   stack_wdata;

    logic [DATA_W-1:0]   rs1_val, rs2_val, alu_y;
    logic [RA_W-1:0]     rd_idx;
    logic [SA_W-1:0]     push_idx, pop_idx;
    logic [IA_W-1:0]     pc_seq;
    logic [2:0]          exec_fc;
    logic                dest_reg_ok, src1_reg_ok, src2_reg_ok;
    logic                dest_dmem_ok, src2_dmem_ok, dest_imem_ok;
    logic                stk_full, stk_empty;

    assign rd_idx   = ir_q.dest[RA_W-1:0];
    assign rs1_val  = regs_q[ir_q.src1[RA_W-1:0]];
    assign rs2_val  = regs_q[ir_q.src2[RA_W-1:0]];
    assign push_idx = SA_W'(sp_q);
    assign pop_idx  = SA_W'(sp_q - SP_W'(1));
    assign pc_seq   = (32'(pc_q) == IMEM_U - 32'd1) ? '0 : pc_q + IA_W'(1);

    assign dest_reg_ok  = 32'(ir_q.dest) < NUM_REGS_U;
    assign src1_reg_ok  = 32'(ir_q.src1) < NUM_REGS_U;
    assign src2_reg_ok  = 32'(ir_q.src2) < NUM_REGS_U;
    assign dest_dmem_ok = 32'(ir_q.dest) < DMEM_U;
    assign src2_dmem_ok = 32'(ir_q.src2) < DMEM_U;
    assign dest_imem_ok = 32'(ir_q.dest) < IMEM_U;
    assign stk_full     = 32'(sp_q) == STACK_U;
    assign stk_empty    = sp_q == '0;

    mips_alu #(.DATA_W(DATA_W)) u_alu (
        .op (alu_op_e'(ir_q.opcode[1:0])),
        .a  (rs1_val),
        .b  (rs2_val),
        .y  (alu_y)
    );

    // Classify the instruction in IR; index faults take priority over stack faults.
    always_comb begin
        exec_fc = FC_NONE;
        case (ir_q.opcode)
            OP_NOOP, OP_HALT: exec_fc = FC_NONE;
            OP_LOAD: if (!(dest_reg_ok && src2_dmem_ok)) exec_fc = FC_INDEX;
            OP_LDNM: if (!dest_reg_ok) exec_fc = FC_INDEX;
            OP_STR:  if (!(dest_dmem_ok && src2_reg_ok)) exec_fc = FC_INDEX;
            OP_ADD, OP_SUB, OP_XOR, OP_AND:
                if (!(dest_reg_ok && src1_reg_ok && src2_reg_ok)) exec_fc = FC_INDEX;
            OP_JMP:  if (!dest_imem_ok) exec_fc = FC_INDEX;
            OP_JMP0: if (!(dest_imem_ok && src2_reg_ok)) exec_fc = FC_INDEX;
            OP_PUSH: begin
                if (!src2_reg_ok)  exec_fc = FC_INDEX;
                else if (stk_full) exec_fc = FC_STK_FULL;
            end
            OP_POP: begin
                if (!dest_reg_ok)   exec_fc = FC_INDEX;
                else if (stk_empty) exec_fc = FC_STK_EMPTY;
            end
            default: exec_fc = FC_ILLEGAL;
        endcase
    end

    // Next-state, next-architectural-state and memory write enables.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        sp_d            = sp_q;
        ir_d            = ir_q;
        fault_code_d    = fault_code_q;
        regs_d          = regs_q;
        dmem_core_we    = 1'b0;
        dmem_core_addr  = ir_q.dest[DA_W-1:0];
        dmem_core_wdata = rs2_val;
        stack_we        = 1'b0;
        stack_wdata     = rs2_val;
        case (state_q)
            ST_IDLE, ST_HALT, ST_FAULT: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    pc_d         = '0;
                    sp_d         = '0;
                    fault_code_d = FC_NONE;
                    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
                end
            end
            ST_FETCH: begin
                ir_d    = imem[pc_q];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_fc != FC_NONE) begin
                    state_d      = ST_FAULT;
                    fault_code_d = exec_fc;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_seq;
                    case (ir_q.opcode)
                        OP_LOAD: regs_d[rd_idx] = dmem[ir_q.src2[DA_W-1:0]];
                        OP_LDNM: regs_d[rd_idx] = DATA_W'(ir_q.src2);
                        OP_STR:  dmem_core_we = 1'b1;
                        OP_ADD, OP_SUB, OP_XOR, OP_AND: regs_d[rd_idx] = alu_y;
                        OP_JMP:  pc_d = ir_q.dest[IA_W-1:0];
                        OP_JMP0: if (rs2_val == '0) pc_d = ir_q.dest[IA_W-1:0];
                        OP_PUSH: begin
                            stack_we = 1'b1;
                            sp_d     = sp_q + SP_W'(1);
                        end
                        OP_POP: begin
                            regs_d[rd_idx] = stack_mem[pop_idx];
                            sp_d           = sp_q - SP_W'(1);
                        end
                        OP_HALT: begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural state registers; memories below are deliberately not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            sp_q         <= '0;
            ir_q         <= '0;
            fault_code_q <= FC_NONE;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            ir_q         <= ir_d;
            fault_code_q <= fault_code_d;
            regs_q       <= regs_d;
        end
    end

    // Instruction memory: host-only writes, blocked while the core runs.
    always_ff @(posedge clk) begin
        if (imem_we && !busy) imem[imem_addr] <= imem_wdata;
    end

    // Data memory: host writes when idle, core STR writes only occur while busy.
    always_ff @(posedge clk) begin
        if (dmem_we && !busy)  dmem[dmem_addr]      <= dmem_wdata;
        else if (dmem_core_we) dmem[dmem_core_addr] <= dmem_core_wdata;
    end

    // Stack storage written by PUSH.
    always_ff @(posedge clk) begin
        if (stack_we) stack_mem[push_idx] <= stack_wdata;
    end

    assign dmem_rdata = dmem[dmem_addr];
    assign busy       = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted     = state_q == ST_HALT;
    assign fault      = state_q == ST_FAULT;
    assign fault_code = fault_code_q;
    assign pc         = pc_q;
    assign ret_val    = regs_q[NUM_REGS-1];

endmodule

// File: tb/tb_mips_core_p.sv
// Directed scoreboard bench for mips_core_p with default parameters.
module tb_mips_core_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        dmem_we;
    logic [4:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        busy, halted, fault;
    logic [2:0]  fault_code;
    logic [4:0]  pc;
    logic [31:0] ret_val;

    int          vectors = 0;
    int          misses  = 0;
    int          cyc;
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] prog  [$];

    mips_core_p dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault),
        .fault_code (fault_code),
        .pc         (pc),
        .ret_val    (ret_val)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_v(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        vectors++;
        if (exp_q.size() == 0) begin
            misses++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                misses++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic imem_w(input logic [4:0] a, input logic [31:0] d);
        imem_we = 1'b1; imem_addr = a; imem_wdata = d;
        @(posedge clk); @(negedge clk);
        imem_we = 1'b0;
    endtask

    task automatic dmem_w(input logic [4:0] a, input logic [31:0] d);
        dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d;
        @(posedge clk); @(negedge clk);
        dmem_we = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) imem_w(5'(i), prog[i]);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while (busy && n < lim) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        vectors++;
        assert (!busy) else begin
            misses++;
            $error("FAIL run_timeout busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic run(input int lim, output int n);
        start_pulse();
        wait_idle(lim, n);
    endtask

    task automatic read_dmem(input logic [4:0] a);
        dmem_addr = a;
        #1;
        check_v(dmem_rdata);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
        dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
        @(negedge clk); @(negedge clk);

        // reset values
        expect_v("rst_busy", 0); expect_v("rst_halted", 0); expect_v("rst_fault", 0);
        expect_v("rst_fcode", 0); expect_v("rst_pc", 0); expect_v("rst_ret", 0);
        check_v({31'b0, busy}); check_v({31'b0, halted}); check_v({31'b0, fault});
        check_v({29'b0, fault_code}); check_v({27'b0, pc}); check_v(ret_val);
        rst_n = 1'b1;
        @(negedge clk);

        // LDNM/LDNM/ADD/STR/HALT
        prog = '{32'h02010005, 32'h02020007, 32'h04030102, 32'h03040003, 32'h0C000000};
        load_prog();
        expect_v("p1_cycles", 10); expect_v("p1_halted", 1); expect_v("p1_busy", 0);
        expect_v("p1_dmem4", 12);
        run(100, cyc);
        check_v(32'(cyc)); check_v({31'b0, halted}); check_v({31'b0, busy});
        read_dmem(5'd4);

        // SUB underflow wraps to all ones
        prog = '{32'h02010000, 32'h02020001, 32'h050F0102, 32'h0305000F, 32'h0C000000};
        load_prog();
        expect_v("p2_ret", 32'hFFFF_FFFF); expect_v("p2_dmem5", 32'hFFFF_FFFF);
        run(100, cyc);
        check_v(ret_val);
        read_dmem(5'd5);

        // POP on empty stack
        prog = '{32'h020F0009, 32'h0B0F0000};
        load_prog();
        expect_v("p3_cycles", 4); expect_v("p3_fault", 1); expect_v("p3_fcode", 3);
        expect_v("p3_pc", 1); expect_v("p3_ret", 9); expect_v("p3_halted", 0);
        run(100, cyc);
        check_v(32'(cyc)); check_v({31'b0, fault}); check_v({29'b0, fault_code});
        check_v({27'b0, pc}); check_v(ret_val); check_v({31'b0, halted});

        // 33rd PUSH overflows: 32 x (PUSH, JMP) then faulting PUSH
        prog = '{32'h0A000000, 32'h08000000};
        load_prog();
        expect_v("p4_cycles", 130); expect_v("p4_fcode", 2); expect_v("p4_pc", 0);
        run(500, cyc);
        check_v(32'(cyc)); check_v({29'b0, fault_code}); check_v({27'b0, pc});

        // JMP0 countdown loop, iteration count stored in DMEM[7]
        prog = '{32'h02010003, 32'h02020001, 32'h09060001, 32'h05010102,
                 32'h04040402, 32'h08020000, 32'h03070004, 32'h0C000000};
        load_prog();
        expect_v("p5_cycles", 34); expect_v("p5_halted", 1); expect_v("p5_fault", 0);
        expect_v("p5_dmem7", 3);
        run(200, cyc);
        check_v(32'(cyc)); check_v({31'b0, halted}); check_v({31'b0, fault});
        read_dmem(5'd7);

        // LOAD from host-written DMEM, AND and XOR
        dmem_w(5'd9, 32'hDEADBEEF);
        prog = '{32'h01010009, 32'h020200FF, 32'h070F0102, 32'h06030102,
                 32'h030A0003, 32'h0C000000};
        load_prog();
        expect_v("p6_ret_and", 32'h0000_00EF); expect_v("p6_dmem10_xor", 32'hDEAD_BE10);
        run(100, cyc);
        check_v(ret_val);
        read_dmem(5'd10);

        // illegal opcode
        prog = '{32'hFF000000};
        load_prog();
        expect_v("p7_fault", 1); expect_v("p7_fcode", 1); expect_v("p7_pc", 0);
        run(100, cyc);
        check_v({31'b0, fault}); check_v({29'b0, fault_code}); check_v({27'b0, pc});

        // register index 16 out of range, then jump target 32 out of range
        prog = '{32'h02100001};
        load_prog();
        expect_v("p8_reg_fcode", 4); expect_v("p8_reg_ret", 0);
        run(100, cyc);
        check_v({29'b0, fault_code}); check_v(ret_val);
        prog = '{32'h08200000};
        load_prog();
        expect_v("p8_jmp_fcode", 4); expect_v("p8_jmp_pc", 0);
        run(100, cyc);
        check_v({29'b0, fault_code}); check_v({27'b0, pc});

        // IMEM write while busy is ignored; rerun confirms; idle write+start applies
        prog = '{32'h020F0011, 32'h00000000, 32'h00000000, 32'h0C000000};
        load_prog();
        expect_v("p9_busy_cycles", 7); expect_v("p9_ret_first", 32'h11);
        expect_v("p9_ret_rerun", 32'h11); expect_v("p9_ret_startwrite", 32'h22);
        start_pulse();
        imem_w(5'd0, 32'h020F0022);
        wait_idle(100, cyc);
        check_v(32'(cyc)); check_v(ret_val);
        run(100, cyc);
        check_v(ret_val);
        imem_we = 1'b1; imem_addr = 5'd0; imem_wdata = 32'h020F0022; start = 1'b1;
        @(posedge clk); @(negedge clk);
        imem_we = 1'b0; start = 1'b0;
        wait_idle(100, cyc);
        check_v(ret_val);

        // async reset during EXEC of STR leaves the target word untouched
        dmem_w(5'd12, 32'h0000_1234);
        prog = '{32'h020F005A, 32'h030C000F, 32'h0C000000};
        load_prog();
        expect_v("p10_pre_ret", 32'h5A); expect_v("p10_busy", 0); expect_v("p10_ret", 0);
        expect_v("p10_pc", 0); expect_v("p10_halted", 0); expect_v("p10_fault", 0);
        expect_v("p10_fcode", 0); expect_v("p10_dmem12", 32'h0000_1234);
        start_pulse();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_v(ret_val);
        rst_n = 1'b0;
        #1;
        check_v({31'b0, busy}); check_v(ret_val); check_v({27'b0, pc});
        check_v({31'b0, halted}); check_v({31'b0, fault}); check_v({29'b0, fault_code});
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        read_dmem(5'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
